// File: rtl/mag_cmp_pkg.sv
// Shared types and constants for the sliced magnitude-compare sequencer.
// Result bit positions line up with uo_out[0..2] in the wrapper.
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int CMP_GT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 2;

  function automatic int nslice(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mag_cmp2.sv
// Combinational 2-bit magnitude compare slice; exactly one output is high.
module mag_cmp2 (
  input  logic [1:0] a2,
  input  logic [1:0] b2,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a2 > b2);
  assign eq = (a2 == b2);
  assign lt = (a2 < b2);

endmodule

// File: rtl/mag_cmp_seq_ctrl.sv
// Compares two WIDTH-bit operands MSB slice first through one shared 2-bit slice.
// Result and slice count are held from done until the next accepted start.
module mag_cmp_seq_ctrl
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      busy,
  output logic                      done,
  output logic                      gt,
  output logic                      eq,
  output logic                      lt,
  output logic [$clog2(WIDTH/2):0]  cycles
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CW     = $clog2(NSLICE) + 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic [2:0]        res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic              pend_gt_q, pend_gt_d;

  logic [1:0]        a_sl, b_sl;
  logic              s_gt, s_eq, s_lt;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[2*i +: 2];
        b_sl = b_q[2*i +: 2];
      end
    end
  end

  mag_cmp2 u_slice (
    .a2 (a_sl),
    .b2 (b_sl),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    cycles_d  = cycles_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    pend_gt_d = pend_gt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = IDXW'(NSLICE - 1);
          cycles_d  = '0;
          res_d     = '0;
          pend_d    = 1'b0;
          pend_gt_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = COMPARE;
        end
      end

      COMPARE: begin
        cycles_d = cycles_q + CW'(1);
        // Only the most significant unequal slice decides the result.
        if (!s_eq && !pend_q) begin
          pend_d    = 1'b1;
          pend_gt_d = s_gt;
        end
        if (((EARLY_EXIT != 0) && !s_eq) || (idx_q == '0)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (pend_q) begin
            res_d[CMP_GT] = pend_gt_q;
            res_d[CMP_LT] = !pend_gt_q;
          end else if (!s_eq) begin
            res_d[CMP_GT] = s_gt;
            res_d[CMP_LT] = s_lt;
          end else begin
            res_d[CMP_EQ] = 1'b1;
          end
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      cycles_q  <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_gt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      cycles_q  <= cycles_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      pend_gt_q <= pend_gt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign gt     = res_q[CMP_GT];
  assign eq     = res_q[CMP_EQ];
  assign lt     = res_q[CMP_LT];
  assign cycles = cycles_q;

endmodule

// File: tb/tb_mag_cmp_seq_ctrl.sv
// Scoreboard bench: early-exit, constant-time and WIDTH=2 instances share clk/rst.
module tb_mag_cmp_seq_ctrl;

  typedef struct {
    logic [2:0] res;   // {lt, eq, gt}
    int         cyc;
  } exp_t;

  localparam logic [2:0] R_GT = 3'b001;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_e, busy_e, done_e, gt_e, eq_e, lt_e;
  logic [7:0] a_e, b_e;
  logic [2:0] cyc_e;
  logic       s_l, busy_l, done_l, gt_l, eq_l, lt_l;
  logic [7:0] a_l, b_l;
  logic [2:0] cyc_l;
  logic       s_w, busy_w, done_w, gt_w, eq_w, lt_w;
  logic [1:0] a_w, b_w;
  logic [0:0] cyc_w;

  mag_cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst(rst), .start(s_e), .a(a_e), .b(b_e), .busy(busy_e), .done(done_e),
    .gt(gt_e), .eq(eq_e), .lt(lt_e), .cycles(cyc_e));

  mag_cmp_seq_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_late (
    .clk(clk), .rst(rst), .start(s_l), .a(a_l), .b(b_l), .busy(busy_l), .done(done_l),
    .gt(gt_l), .eq(eq_l), .lt(lt_l), .cycles(cyc_l));

  mag_cmp_seq_ctrl #(.WIDTH(2), .EARLY_EXIT(1)) u_w2 (
    .clk(clk), .rst(rst), .start(s_w), .a(a_w), .b(b_w), .busy(busy_w), .done(done_w),
    .gt(gt_w), .eq(eq_w), .lt(lt_w), .cycles(cyc_w));

  exp_t q_e[$], q_l[$], q_w[$];
  int vectors = 0;
  int errors  = 0;

  // Result, slice count, busy duration and clean outputs while busy, all at done.
  task automatic chk(input string nm, input logic [2:0] res, input int cyc,
                     input int bcnt, input bit dirty, input logic bsy, input exp_t e);
    vectors++;
    if (res !== e.res || cyc != e.cyc || bcnt != e.cyc || dirty || bsy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got res=%b cycles=%0d busy_cycles=%0d dirty=%0b busy=%b, want res=%b cycles=%0d busy_cycles=%0d",
               nm, res, cyc, bcnt, dirty, bsy, e.res, e.cyc, e.cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    errors++;
    $display("FAIL %s: done pulse with no outstanding compare (got 1, want 0)", nm);
  endtask

  int  bc_e = 0, bc_l = 0, bc_w = 0;
  bit  dt_e = 0, dt_l = 0, dt_w = 0;

  always @(negedge clk) begin
    if (done_e) begin
      if (q_e.size() == 0) unexpected("early");
      else chk("early", {lt_e, eq_e, gt_e}, int'(cyc_e), bc_e, dt_e, busy_e, q_e.pop_front());
      bc_e = 0; dt_e = 0;
    end else if (busy_e) begin
      bc_e++;
      if (gt_e | eq_e | lt_e) dt_e = 1;
    end else begin
      bc_e = 0; dt_e = 0;
    end
  end

  always @(negedge clk) begin
    if (done_l) begin
      if (q_l.size() == 0) unexpected("const");
      else chk("const", {lt_l, eq_l, gt_l}, int'(cyc_l), bc_l, dt_l, busy_l, q_l.pop_front());
      bc_l = 0; dt_l = 0;
    end else if (busy_l) begin
      bc_l++;
      if (gt_l | eq_l | lt_l) dt_l = 1;
    end else begin
      bc_l = 0; dt_l = 0;
    end
  end

  always @(negedge clk) begin
    if (done_w) begin
      if (q_w.size() == 0) unexpected("w2");
      else chk("w2", {lt_w, eq_w, gt_w}, int'(cyc_w), bc_w, dt_w, busy_w, q_w.pop_front());
      bc_w = 0; dt_w = 0;
    end else if (busy_w) begin
      bc_w++;
      if (gt_w | eq_w | lt_w) dt_w = 1;
    end else begin
      bc_w = 0; dt_w = 0;
    end
  end

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic done_of(input int w);
    case (w)
      0:       return done_e;
      1:       return done_l;
      default: return done_w;
    endcase
  endfunction

  task automatic wait_done(input int w, input string nm);
    int n = 0;
    while (!done_of(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      errors++;
      $display("FAIL %s: done never seen (got 0 within 40 cycles, want 1)", nm);
    end
  endtask

  // One-cycle start pulse on instance w; expected result queued at issue time.
  task automatic go(input int w, input logic [7:0] av, input logic [7:0] bv,
                    input logic [2:0] r, input int c);
    exp_t e;
    e.res = r;
    e.cyc = c;
    @(negedge clk);
    case (w)
      0: begin s_e = 1; a_e = av; b_e = bv; q_e.push_back(e); end
      1: begin s_l = 1; a_l = av; b_l = bv; q_l.push_back(e); end
      default: begin s_w = 1; a_w = av[1:0]; b_w = bv[1:0]; q_w.push_back(e); end
    endcase
    @(negedge clk);
    s_e = 0; s_l = 0; s_w = 0;
    wait_done(w, "go");
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] r;
    int         c;
  } vec_t;

  vec_t ev[6] = '{
    '{8'hC3, 8'h43, R_GT, 1},
    '{8'h5A, 8'h5A, R_EQ, 4},
    '{8'h12, 8'h13, R_LT, 4},
    '{8'h00, 8'hFF, R_LT, 1},
    '{8'h80, 8'h90, R_LT, 2},
    '{8'hA7, 8'hA4, R_GT, 4}
  };

  vec_t lv[4] = '{
    '{8'hC3, 8'h43, R_GT, 4},
    '{8'h01, 8'h00, R_GT, 4},
    '{8'h5A, 8'h5A, R_EQ, 4},
    '{8'h00, 8'hFF, R_LT, 4}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst = 1;
    s_e = 0; a_e = 0; b_e = 0;
    s_l = 0; a_l = 0; b_l = 0;
    s_w = 0; a_w = 0; b_w = 0;
    repeat (2) @(negedge clk);
    expect_eq("reset_early", {busy_e, done_e, gt_e, eq_e, lt_e, 1'b0, cyc_e}, 32'h0);
    expect_eq("reset_const", {busy_l, done_l, gt_l, eq_l, lt_l, 1'b0, cyc_l}, 32'h0);
    expect_eq("reset_w2",    {busy_w, done_w, gt_w, eq_w, lt_w, cyc_w}, 32'h0);
    rst = 0;
    @(negedge clk);

    foreach (ev[i]) go(0, ev[i].a, ev[i].b, ev[i].r, ev[i].c);
    foreach (lv[i]) go(1, lv[i].a, lv[i].b, lv[i].r, lv[i].c);

    // Start re-pulsed with new operands mid-compare must be ignored.
    @(negedge clk);
    s_e = 1; a_e = 8'h5A; b_e = 8'h5A;
    e.res = R_EQ; e.cyc = 4; q_e.push_back(e);
    @(negedge clk);
    a_e = 8'h00; b_e = 8'hFF;
    repeat (2) @(negedge clk);
    s_e = 0;
    wait_done(0, "ignore_start");
    repeat (6) @(negedge clk);

    // Start held high: three back-to-back compares, one idle cycle apart.
    s_e = 1; a_e = 8'h12; b_e = 8'h13;
    e.res = R_LT; e.cyc = 4;
    repeat (3) q_e.push_back(e);
    for (int k = 0; k < 3; k++) begin
      wait_done(0, "held_start");
      if (k < 2) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!busy_e && n < 10);
        expect_eq("held_gap", n, 2);
      end
    end
    s_e = 0;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the second compare cycle.
    s_e = 1; a_e = 8'h5A; b_e = 8'h5A;
    @(negedge clk);
    s_e = 0;
    @(negedge clk);
    #2 rst = 1;
    #1 expect_eq("async_rst", {busy_e, done_e, gt_e, eq_e, lt_e, 1'b0, cyc_e}, 32'h0);
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    go(0, 8'hC3, 8'h43, R_GT, 1);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        go(2, 8'(i), 8'(j), (i > j) ? R_GT : ((i == j) ? R_EQ : R_LT), 1);
      end
    end

    repeat (4) @(negedge clk);
    expect_eq("pending_early", q_e.size(), 0);
    expect_eq("pending_const", q_l.size(), 0);
    expect_eq("pending_w2",    q_w.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
